// File: rtl/seq_detect_prog_if.sv
// Bundle of serial-data, configuration and status signals for seq_detect_prog.
// en qualifies x with no backpressure: a bit is consumed on every rising clk edge where en is high.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
) ();
  logic               en;
  logic               x;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               z;
  logic [CNT_W-1:0]   match_count;
  logic               armed;
  logic               cfg_err;

  modport master (
    output en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    input  z, match_count, armed, cfg_err
  );

  modport slave (
    input  en, x, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    output z, match_count, armed, cfg_err
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector with a registered one-cycle match flag,
// overlap/non-overlap matching and a saturating match counter.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input logic               clk,
  input logic               rst,
  seq_detect_prog_if.slave  bus
);

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LW-1:0]      fill_q, fill_d;
  logic [LW-1:0]      len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               z_q, z_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               armed_q, armed_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      fill_inc;
  logic               cfg_ok;
  logic               load_ok;
  logic               hit;

  always_comb begin
    cfg_ok   = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(MAX_LEN));
    load_ok  = bus.cfg_load && cfg_ok;
    shifted  = {hist_q[MAX_LEN-2:0], bus.x};
    fill_inc = (fill_q == LW'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    // Only the low len bits take part; fill gates out stale history.
    hit = bus.en && !load_ok && (fill_inc >= len_q) &&
          ((shifted & mask) == (pat_q & mask));
  end

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    z_d     = 1'b0;
    count_d = count_q;
    err_d   = bus.cfg_load && !cfg_ok;

    if (load_ok) begin
      pat_d  = bus.cfg_pattern;
      len_d  = bus.cfg_len;
      ovl_d  = bus.cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.en) begin
      hist_d = shifted;
      fill_d = (hit && !ovl_q) ? '0 : fill_inc;
      z_d    = hit;
    end

    if (bus.clr_count) begin
      count_d = '0;
    end else if (hit && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end

    armed_d = (fill_d >= len_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= MAX_LEN'(5'b10011);
      len_q   <= LW'(5);
      ovl_q   <= 1'b1;
      z_q     <= 1'b0;
      count_q <= '0;
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      z_q     <= z_d;
      count_q <= count_d;
      armed_q <= armed_d;
      err_q   <= err_d;
    end
  end

  assign bus.z           = z_q;
  assign bus.match_count = count_q;
  assign bus.armed       = armed_q;
  assign bus.cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed test-plan steps followed by random traffic,
// all checked against a bit-queue reference model.
module tb_seq_detect_prog;
  localparam int ML   = 8;
  localparam int CW   = 2;
  localparam int LW   = $clog2(ML + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;

  seq_detect_prog_if #(.MAX_LEN(ML), .CNT_W(CW)) bus ();

  seq_detect_prog #(.MAX_LEN(ML), .CNT_W(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the bits accepted since the last reset, load or
  // non-overlapping match, oldest first.
  bit          q_bits[$];
  logic [ML-1:0] m_pat;
  int          m_len;
  bit          m_ovl;
  int          m_cnt;
  bit          m_z, m_armed, m_err;

  task automatic model_reset();
    q_bits.delete();
    m_pat   = 8'h13;
    m_len   = 5;
    m_ovl   = 1'b1;
    m_cnt   = 0;
    m_z     = 1'b0;
    m_armed = 1'b0;
    m_err   = 1'b0;
  endtask

  function automatic bit model_match();
    if (q_bits.size() < m_len) return 1'b0;
    // Pattern bit [0] is the most recently received bit.
    for (int i = 0; i < m_len; i++) begin
      if (q_bits[q_bits.size() - 1 - i] != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("z",       int'(bus.z),           int'(m_z));
    chk("count",   int'(bus.match_count), m_cnt);
    chk("armed",   int'(bus.armed),       int'(m_armed));
    chk("cfg_err", int'(bus.cfg_err),     int'(m_err));
  endtask

  task automatic cycle(input bit en, input bit x, input bit ld = 1'b0,
                       input logic [ML-1:0] pat = '0, input int len = 0,
                       input bit ovl = 1'b0, input bit clr = 1'b0);
    bit valid;
    bus.en          = en;
    bus.x           = x;
    bus.cfg_load    = ld;
    bus.cfg_pattern = pat;
    bus.cfg_len     = LW'(len);
    bus.cfg_overlap = ovl;
    bus.clr_count   = clr;
    @(posedge clk);
    valid = ld && (len >= 1) && (len <= ML);
    m_err = ld && !valid;
    m_z   = 1'b0;
    if (valid) begin
      m_pat = pat;
      m_len = len;
      m_ovl = ovl;
      q_bits.delete();
    end else if (en) begin
      q_bits.push_back(x);
      if (q_bits.size() > ML) void'(q_bits.pop_front());
      if (model_match()) begin
        m_z = 1'b1;
        if (m_cnt < CMAX) m_cnt++;
        if (!m_ovl) q_bits.delete();
      end
    end
    if (clr) m_cnt = 0;
    m_armed = (q_bits.size() >= m_len);
    #1;
    check_outputs();
  endtask

  task automatic feed(input bit b);
    cycle(1'b1, b);
  endtask

  task automatic feed_list(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) feed(bits[i]);
  endtask

  // Reset asserted mid-cycle; the asynchronous clear is checked before any edge.
  task automatic do_reset();
    bus.en = 1'b0; bus.cfg_load = 1'b0; bus.clr_count = 1'b0;
    rst = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 1'b0; bus.x = 1'b0; bus.cfg_load = 1'b0; bus.cfg_pattern = '0;
    bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.clr_count = 1'b0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Default 10011 with overlap: matches after bits 5 and 9.
    feed_list(16'b1_0011_0011, 9);
    chk("dflt_count", int'(bus.match_count), 2);
    cycle(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);

    // 101 overlapping then non-overlapping on 10101.
    cycle(1'b0, 1'b0, 1'b1, 8'b101, 3, 1'b1);
    feed_list(16'b10101, 5);
    chk("ovl_count", int'(bus.match_count), 2);
    cycle(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 8'b101, 3, 1'b0);
    feed_list(16'b10101, 5);
    chk("novl_count", int'(bus.match_count), 1);

    // en gaps inside the default pattern.
    do_reset();
    feed_list(16'b100, 3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    feed_list(16'b11, 2);
    chk("gap_count", int'(bus.match_count), 1);

    // Reset after bit 4 loses the partial match.
    do_reset();
    feed_list(16'b1001, 4);
    do_reset();
    feed(1'b1);
    chk("rst_count", int'(bus.match_count), 0);

    // Rejected loads leave 10011/5 active; the bit in that cycle is consumed.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 8'hFF, 0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 8'hFF, ML + 1, 1'b0);
    feed_list(16'b011, 3);
    chk("badcfg_count", int'(bus.match_count), 1);

    // Valid load together with en: bit dropped, not armed.
    cycle(1'b1, 1'b1, 1'b1, 8'h01, 1, 1'b1);
    chk("load_en_armed", int'(bus.armed), 0);
    cycle(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b1);

    // Counter saturation with a single-bit pattern, then clear against a match.
    for (int i = 0; i < 6; i++) feed(1'b1);
    chk("sat_count", int'(bus.match_count), CMAX);
    cycle(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
    chk("clr_z", int'(bus.z), 1);

    // Full-length pattern A5.
    cycle(1'b0, 1'b0, 1'b1, 8'hA5, 8, 1'b1);
    feed_list(16'hA5, 8);
    chk("full_z", int'(bus.z), 1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 19) == 0) begin
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
              ML'($urandom), $urandom_range(0, ML + 1), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 29) == 0));
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
              '0, 0, 1'b0, 1'($urandom_range(0, 29) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
